// File: rtl/scarv_soc_pkg.sv
// Shared SoC reset-source definitions: FSM state encoding and reset_cause bit indices.
package scarv_soc_pkg;

    typedef enum logic [1:0] {
        RST_RUN      = 2'd0,
        RST_HOLD     = 2'd1,
        RST_WAIT_REL = 2'd2
    } rst_state_e;

    localparam int CAUSE_W   = 4;
    localparam int CAUSE_POR = 0;
    localparam int CAUSE_BTN = 1;
    localparam int CAUSE_SW  = 2;
    localparam int CAUSE_WDT = 3;

endpackage

// File: rtl/scarv_soc_debounce.sv
// Button synchroniser and debouncer: 2-flop sync of the raw pin, then a saturating
// press counter that fires a single-cycle trigger once the press has been stable.
module scarv_soc_debounce #(
    parameter bit          ACTIVE_HIGH = 1'b1,
    parameter int unsigned CYCLES      = 1024
) (
    input  logic f_clk,
    input  logic f_reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_trig
);

    // One extra count value lets the counter park past the trigger point.
    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic          pressed_raw;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    assign pressed_raw = ACTIVE_HIGH ? btn_raw : ~btn_raw;

    always_ff @(posedge f_clk) begin
        if (f_reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], pressed_raw};
            if (!sync_q[1])
                cnt_q <= '0;
            else if (cnt_q != CW'(CYCLES))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign btn_level = sync_q[1];
    assign btn_trig  = sync_q[1] && (cnt_q == CW'(CYCLES - 1));

endmodule

// File: rtl/scarv_soc_reset_src.sv
// Reset-source arbiter: merges button, software key and optional watchdog into one
// fixed-length sys_reset pulse and keeps a sticky cause register.
// Watchdog is built only when SCARV_SOC_RESET_SRC_WDT_EN is defined.
module scarv_soc_reset_src
    import scarv_soc_pkg::*;
#(
    parameter bit          BTN_ACTIVE_HIGH = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned PULSE_CYCLES    = 32,
    parameter int unsigned WDT_TIMEOUT     = 2**20,
    parameter logic [7:0]  SW_RESET_KEY    = 8'hA5
) (
    input  logic               f_clk,
    input  logic               f_reset,
    input  logic               btn_reset,
    input  logic               sw_reset_req,
    input  logic [7:0]         sw_reset_key,
    input  logic               wdt_enable,
    input  logic               wdt_kick,
    input  logic               cause_clr,
    output logic               sys_reset,
    output logic [CAUSE_W-1:0] reset_cause
);

    localparam int unsigned HW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    rst_state_e         state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               sys_reset_q;
    logic [CAUSE_W-1:0] cause_q, cause_d, trig_vec;
    logic               btn_level, btn_trig, sw_trig, wdt_trig, any_trig;

    scarv_soc_debounce #(
        .ACTIVE_HIGH (BTN_ACTIVE_HIGH),
        .CYCLES      (DEBOUNCE_CYCLES)
    ) u_debounce (
        .f_clk     (f_clk),
        .f_reset   (f_reset),
        .btn_raw   (btn_reset),
        .btn_level (btn_level),
        .btn_trig  (btn_trig)
    );

    assign sw_trig = sw_reset_req && (sw_reset_key == SW_RESET_KEY);

`ifdef SCARV_SOC_RESET_SRC_WDT_EN
    localparam int unsigned WW = $clog2(WDT_TIMEOUT);

    logic [WW-1:0] wdt_q;

    // A kick in the expiry cycle wins over the timeout.
    assign wdt_trig = wdt_enable && !wdt_kick && (state_q == RST_RUN) &&
                      (wdt_q == WW'(WDT_TIMEOUT - 1));

    always_ff @(posedge f_clk) begin
        if (f_reset || wdt_kick || !wdt_enable || (state_q != RST_RUN) || wdt_trig)
            wdt_q <= '0;
        else
            wdt_q <= wdt_q + 1'b1;
    end
`else
    logic unused_wdt;

    assign wdt_trig   = 1'b0;
    assign unused_wdt = ^{wdt_enable, wdt_kick, WDT_TIMEOUT[0]};
`endif

    always_comb begin
        trig_vec            = '0;
        trig_vec[CAUSE_BTN] = btn_trig;
        trig_vec[CAUSE_SW]  = sw_trig;
        trig_vec[CAUSE_WDT] = wdt_trig;
    end

    assign any_trig = |trig_vec;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            RST_RUN: begin
                if (any_trig) begin
                    state_d = RST_HOLD;
                    hold_d  = '0;
                end
            end
            RST_HOLD: begin
                // Triggers here only touch the cause register, never the length.
                if (hold_q == HW'(PULSE_CYCLES - 1))
                    state_d = btn_level ? RST_WAIT_REL : RST_RUN;
                else
                    hold_d = hold_q + 1'b1;
            end
            RST_WAIT_REL: begin
                if (any_trig) begin
                    state_d = RST_HOLD;
                    hold_d  = '0;
                end else if (!btn_level) begin
                    state_d = RST_RUN;
                end
            end
            default: begin
                state_d = RST_HOLD;
                hold_d  = '0;
            end
        endcase
    end

    // Clear is applied first so a same-cycle trigger still lands.
    assign cause_d = (cause_clr ? '0 : cause_q) | trig_vec;

    always_ff @(posedge f_clk) begin
        if (f_reset) begin
            state_q     <= RST_HOLD;
            hold_q      <= '0;
            sys_reset_q <= 1'b1;
            cause_q     <= CAUSE_W'(1) << CAUSE_POR;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            sys_reset_q <= (state_d == RST_HOLD);
            cause_q     <= cause_d;
        end
    end

    assign sys_reset   = sys_reset_q;
    assign reset_cause = cause_q;

endmodule
